// File: rtl/mux_nx1_seq_pkg.sv
// Shared constants for the registered N-to-1 channel mux: mode codes, FSM encodings, stats sizing.
// Optional statistics ports are enabled by defining MUX_STATS_EN.
package mux_nx1_seq_pkg;

    localparam logic       MODE_MANUAL = 1'b0;
    localparam logic       MODE_RR     = 1'b1;

    localparam logic [0:0] ST_EMPTY    = 1'b0;
    localparam logic [0:0] ST_FULL     = 1'b1;

    localparam int         STAT_W      = 16;
    localparam int         STARVE_THR  = 16;

    // Channel-index width, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_nx1_seq_rr_pick.sv
// Combinational first-valid search starting at ptr and wrapping modulo N_CH.
// Zero latency; no backpressure of its own.
module rr_pick
    import mux_nx1_seq_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = idx_w(N_CH)
) (
    input  logic [N_CH-1:0]  valid,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] chosen,
    output logic             found
);

    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        chosen = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(ptr) + i) % N_CH;
            if (!found && valid[idx]) begin
                found  = 1'b1;
                chosen = idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_nx1_seq.sv
// Registered N-to-1 mux, manual-select or round-robin scan; 1 cycle accept -> out_valid.
// Backpressure: a held word blocks all in_ready until out_ready; drain+load same edge. Stats: MUX_STATS_EN.
module mux_nx1_seq
    import mux_nx1_seq_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = idx_w(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef MUX_STATS_EN
    ,
    output logic [STAT_W-1:0]     xfer_cnt,
    output logic [N_CH-1:0]       starve
`endif
);

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] ch_q, ch_d;

    logic             load_en, load, found;
    logic [SEL_W-1:0] chosen, pick_ptr;
    logic [N_CH-1:0]  sel_mask, pick_valid;

    assign load_en = (state_q == ST_EMPTY) | out_ready;

    // Manual mode reuses the RR search with a one-hot mask, so an out-of-range sel finds nothing.
    always_comb begin
        sel_mask = '0;
        if (int'(sel) < N_CH) sel_mask[sel] = 1'b1;
    end

    assign pick_valid = (mode == MODE_RR) ? in_valid : (in_valid & sel_mask);
    assign pick_ptr   = (mode == MODE_RR) ? ptr_q : sel;

    rr_pick #(.N_CH(N_CH)) u_pick (
        .valid  (pick_valid),
        .ptr    (pick_ptr),
        .chosen (chosen),
        .found  (found)
    );

    assign load = load_en & found;

    always_comb begin
        in_ready = '0;
        if (load) in_ready[chosen] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        ch_d    = ch_q;
        if (load) begin
            state_d = ST_FULL;
            data_d  = in_data[chosen*WIDTH +: WIDTH];
            ch_d    = chosen;
            if (mode == MODE_RR)
                ptr_d = (int'(chosen) == N_CH-1) ? '0 : chosen + 1'b1;
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;

`ifdef MUX_STATS_EN
    localparam int WAIT_W = $clog2(STARVE_THR) + 1;

    logic [STAT_W-1:0] xfer_q, xfer_d;
    logic [N_CH-1:0]   starve_q, starve_d, hold;
    logic [WAIT_W-1:0] wait_q [N_CH];
    logic [WAIT_W-1:0] wait_d [N_CH];

    assign hold = in_valid & ~in_ready;

    always_comb begin
        xfer_d = xfer_q;
        if (out_valid & out_ready & ~(&xfer_q)) xfer_d = xfer_q + 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            // Wait counter saturates at the threshold; starve latches until the channel is accepted.
            if (!hold[c])
                wait_d[c] = '0;
            else if (wait_q[c] == WAIT_W'(STARVE_THR))
                wait_d[c] = wait_q[c];
            else
                wait_d[c] = wait_q[c] + 1'b1;
            if (in_ready[c])
                starve_d[c] = 1'b0;
            else if (hold[c] && wait_q[c] == WAIT_W'(STARVE_THR-1))
                starve_d[c] = 1'b1;
            else
                starve_d[c] = starve_q[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_q   <= '0;
            starve_q <= '0;
            for (int c = 0; c < N_CH; c++) wait_q[c] <= '0;
        end else begin
            xfer_q   <= xfer_d;
            starve_q <= starve_d;
            for (int c = 0; c < N_CH; c++) wait_q[c] <= wait_d[c];
        end
    end

    assign xfer_cnt = xfer_q;
    assign starve   = starve_q;
`endif

endmodule

// File: tb/tb_mux_nx1_seq.sv
// Scoreboard bench for mux_nx1_seq (N_CH=4 main instance, N_CH=3 out-of-range instance).
module tb_mux_nx1_seq;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           mode;
    logic [1:0]     sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;
    logic           out_valid, out_ready;

    logic           mode3;
    logic [1:0]     sel3;
    logic [3*W-1:0] in_data3;
    logic [2:0]     in_valid3, in_ready3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_ch3;
    logic           out_valid3, out_ready3;

`ifdef MUX_STATS_EN
    logic [15:0]    xfer_cnt, xfer_cnt3;
    logic [N-1:0]   starve;
    logic [2:0]     starve3;
`endif

    mux_nx1_seq #(.N_CH(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef MUX_STATS_EN
        , .xfer_cnt(xfer_cnt), .starve(starve)
`endif
    );

    mux_nx1_seq #(.N_CH(3), .WIDTH(W)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready3)
`ifdef MUX_STATS_EN
        , .xfer_cnt(xfer_cnt3), .starve(starve3)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic [1:0]   ch;
    } word_t;
    word_t exp_q[$];

    // Reference state: is a word held, where the RR scan starts, stats.
    bit         m_full;
    int         m_ptr;
    int         m_xfer;
    int         m_hold [N];
    bit [N-1:0] m_starve;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int pick(input bit md, input int s, input logic [N-1:0] v, input int p);
        if (!md) return (s < N && v[s]) ? s : -1;
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_full   = 1'b0;
        m_ptr    = 0;
        m_xfer   = 0;
        m_starve = '0;
        for (int c = 0; c < N; c++) m_hold[c] = 0;
    endtask

    task automatic cyc(input bit md, input int s, input logic [N-1:0] v,
                       input logic [N*W-1:0] d, input bit r);
        int         ch;
        logic [N-1:0] exp_rdy;
        bit         hs;
        @(negedge clk);
        mode = md; sel = 2'(s); in_valid = v; in_data = d; out_ready = r;
        #1;
        ch      = (!m_full || r) ? pick(md, s, v, m_ptr) : -1;
        exp_rdy = (ch >= 0) ? N'(1 << ch) : '0;
        hs      = m_full && r;
        check("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        #1;
        if (hs && m_xfer < 65535) m_xfer++;
        for (int c = 0; c < N; c++) begin
            if (v[c] && !exp_rdy[c]) m_hold[c]++; else m_hold[c] = 0;
            if (exp_rdy[c]) m_starve[c] = 1'b0;
            else if (m_hold[c] >= 16) m_starve[c] = 1'b1;
        end
        if (ch >= 0) begin
            exp_q.push_back({d[ch*W +: W], 2'(ch)});
            m_full = 1'b1;
            if (md) m_ptr = (ch + 1) % N;
        end else if (r) begin
            m_full = 1'b0;
        end
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_ch", out_ch, '0);
        model_clear();
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: output must always equal the scoreboard head; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                check("out_valid", out_valid, exp_q.size() != 0);
                if (out_valid && exp_q.size() > 0) begin
                    check("out_data", out_data, exp_q[0].d);
                    check("out_ch", out_ch, exp_q[0].ch);
                    if (out_ready) void'(exp_q.pop_front());
                end
`ifdef MUX_STATS_EN
                check("xfer_cnt", xfer_cnt, m_xfer);
                check("starve", starve, m_starve);
`endif
            end
        end
    end

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
        mode3 = 1'b0; sel3 = 2'd3; in_data3 = 24'h332211; in_valid3 = 3'b111; out_ready3 = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check("init_out_valid", out_valid, 1'b0);
        check("init_out_data", out_data, '0);
        check("init_out_ch", out_ch, '0);
        @(negedge clk);
        rst_n = 1'b1;

        cyc(1'b0, 2, 4'b0100, 32'h00A5_0000, 1'b1);
        cyc(1'b0, 2, 4'b0000, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 0, 4'hF, $urandom, 1'b1);
        cyc(1'b1, 0, 4'b1001, 32'h4433_2211, 1'b1);
        cyc(1'b1, 0, 4'b1001, 32'h4433_2211, 1'b1);
        cyc(1'b0, 0, 4'b0001, 32'h0000_0077, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1, 4'b0011, $urandom, 1'b0);
        cyc(1'b0, 1, 4'b0010, 32'h0000_5A00, 1'b1);
        cyc(1'b0, 3, 4'b0111, $urandom, 1'b1);
        cyc(1'b0, 3, 4'b0111, $urandom, 1'b1);

        cyc(1'b0, 1, 4'b0010, 32'h0000_C300, 1'b0);
        cyc(1'b0, 1, 4'b0010, 32'h0000_C300, 1'b0);
        reset_mid();
        cyc(1'b1, 0, 4'hF, $urandom, 1'b1);
        cyc(1'b1, 0, 4'hF, $urandom, 1'b1);

        for (int i = 0; i < 17; i++) cyc(1'b0, 0, 4'b0100, $urandom, 1'b1);
        cyc(1'b0, 2, 4'b0100, $urandom, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 0, 4'hF, $urandom, 1'b1);

        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3), N'($urandom),
                $urandom, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 4'b0000, 32'h0, 1'b1);
        check("drained", exp_q.size(), 0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            check("oor_in_ready", in_ready3, 3'b000);
            check("oor_out_valid", out_valid3, 1'b0);
        end
        @(negedge clk);
        sel3 = 2'd2;
        #1;
        check("n3_in_ready", in_ready3, 3'b100);
        @(negedge clk);
        #2;
        check("n3_out_valid", out_valid3, 1'b1);
        check("n3_out_ch", out_ch3, 2'd2);
        check("n3_out_data", out_data3, 8'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
